spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//  Transaction controller behind the byte-level SPI slave. Decodes SPI messages
//  (one SSEL-low frame) into read/write bursts on an internal register bus
//  (motor/LED/config registers) and sequences the response bytes for MISO.
//  Sits between the SPI shifter (rx/tx bytes, frame strobes) and the register bank.
// PARAMETERS
//  ADDR_W  7   register address width; the command byte carries the address in cmd[ADDR_W-1:0], ADDR_W<=7
//  DATA_W  8   register data width (fixed to the SPI byte width)
//  MAX_BURST 16  max data bytes per frame; extra bytes are ignored and flag overrun
// PORTS
//  clk        in   1       system clock (SPI signals already synchronised to it)
//  rst        in   1       synchronous reset, active-high
//  msg_start  in   1       1-cycle pulse: SSEL falling edge (frame start)
//  msg_end    in   1       1-cycle pulse: SSEL rising edge (frame end)
//  rx_valid   in   1       1-cycle pulse: full byte received
//  rx_data    in   8       received byte, valid with rx_valid
//  tx_data    out  8       next byte for the shifter to send
//  tx_load    out  1       1-cycle pulse: shifter latches tx_data at its next byte boundary
//  reg_addr   out  ADDR_W  register bus address
//  reg_wdata  out  8       register write data
//  reg_we     out  1       1-cycle write strobe
//  reg_re     out  1       1-cycle read strobe; reg_rdata sampled on the following clk
//  reg_rdata  in   8       register read data
//  busy       out  1       high from msg_start until the FSM returns to IDLE
//  err_ovr    out  1       sticky: burst exceeded MAX_BURST; cleared at the next msg_start
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, msg_cnt=0, addr=0.
//  Frame format: byte0 = cmd {rw(1=read), addr[6:0]}; bytes 1..N = data.
//  FSM states: IDLE, CMD, WR, RD_REQ, RD_LD, DONE.
//   IDLE  : on msg_start -> CMD; cycle+1: tx_data={msg_cnt[3:0],3'b000,err_ovr_prev}, tx_load=1; msg_cnt++ (8-bit, wraps 255->0).
//   CMD   : on rx_valid latch addr=rx_data[ADDR_W-1:0], bytes=0; rw=0 -> WR; rw=1 -> RD_REQ.
//   WR    : each rx_valid: reg_addr=addr, reg_wdata=rx_data, reg_we=1 for exactly 1 cycle, bytes++, addr advance (see CONFIGURATION).
//           tx_data=0x00, tx_load pulse with each rx_valid (master sees zeros).
//   RD_REQ: reg_re=1 (1 cycle) with reg_addr=addr -> RD_LD.
//   RD_LD : capture reg_rdata, tx_data=captured, tx_load=1 (2 clk after entering RD_REQ);
//           then wait rx_valid (byte clocked out); on it bytes++, addr advance -> RD_REQ.
//   DONE  : entered at msg_end from any non-IDLE state; tx_data=0, 1 cycle -> IDLE; busy drops the cycle after DONE.
//  Read prefetch latency: data for byte k+1 requested right after byte k completes; clk >= 16x SCK is required.
//  Rx byte in WR/RD after bytes==MAX_BURST: no reg_we/reg_re, err_ovr=1, tx_data=0xFF.
//  msg_end priority: beats a same-cycle rx_valid (byte dropped, no strobe); msg_end in CMD = empty frame, no bus access.
//  msg_start while not IDLE (glitch/missing end): abort, restart as a fresh frame; a pending strobe for the in-flight byte is not issued.
//  rst mid-frame: immediate IDLE, strobes deasserted that cycle; rest of the frame is ignored until the next msg_start.
//  reg_we and reg_re are never high in the same cycle.
// CONFIGURATION
//  SPI_REG_CTRL_AUTOINC_EN defined: addr increments per data byte, wrapping 2^ADDR_W-1 -> 0.
//  Not defined: addr fixed at the cmd value for the whole burst (FIFO-style register).
// TESTING
//  Write 0x05 then 0xAA,0x55 -> reg_we x2: (0x05,0xAA),(0x06,0x55) [AUTOINC]; (0x05,0xAA),(0x05,0x55) without.
//  Read 0x85, rdata[5]=0x3C, rdata[6]=0xC3, 2 data bytes -> tx bytes: status,0x3C,0xC3; reg_re x2 (3 with prefetch, last unused).
//  Status byte: 3 frames after reset -> first tx bytes 0x00,0x10,0x20; 256 frames -> counter wraps to 0.
//  Write addr 0x7F with 2 bytes [AUTOINC] -> writes to 0x7F then 0x00.
//  17 write bytes, MAX_BURST=16 -> 16 reg_we, err_ovr=1, 17th tx=0xFF; next msg_start clears err_ovr, status bit0=1.
//  rst asserted after cmd byte, before data -> no reg_we/reg_re, all outputs 0 next cycle; msg_end with rx_valid same cycle -> no strobe.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Transaction controller between a byte-level SPI slave and the register bus.
// Optional build macro SPI_REG_CTRL_AUTOINC_EN: burst address auto-increments per data byte.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no frame active, rx bytes ignored
// CMD    | status byte loaded, waiting for the command byte
// WR     | write burst, one reg_we per received data byte
// RD_REQ | issue reg_re for the current burst address
// RD_LD  | capture read data into tx, then wait for the byte to clock out
// DONE   | frame ended, one cycle before returning to IDLE
module spi_reg_ctrl #(
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              msg_start,
   input  logic              msg_end,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_load,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy,
   output logic              err_ovr
);

   localparam int BCNT_W = $clog2(MAX_BURST + 1);
   localparam logic [BCNT_W-1:0] BMAX = BCNT_W'(MAX_BURST);

   typedef enum logic [2:0] {IDLE, CMD, WR, RD_REQ, RD_LD, DONE} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr, addr_nxt, addr_adv;
   logic [BCNT_W-1:0]   bytes, bytes_nxt, bytes_inc;
   logic                loaded, loaded_nxt;
   logic                err_nxt;
   // Only the low nibble of the frame counter is ever visible, and an 8-bit
   // counter wraps onto the same nibble sequence.
   logic [3:0]          msg_cnt, cnt_nxt;
   logic [DATA_W-1:0]   tx_data_nxt, wdata_nxt;
   logic [ADDR_W-1:0]   reg_addr_nxt;
   logic                tx_load_nxt, we_nxt, re_nxt;

`ifdef SPI_REG_CTRL_AUTOINC_EN
   assign addr_adv = addr + ADDR_W'(1);
`else
   assign addr_adv = addr;
`endif

   assign bytes_inc = bytes + BCNT_W'(1);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt    = state;
      addr_nxt     = addr;
      bytes_nxt    = bytes;
      loaded_nxt   = loaded;
      err_nxt      = err_ovr;
      cnt_nxt      = msg_cnt;
      tx_data_nxt  = tx_data;
      tx_load_nxt  = 1'b0;
      we_nxt       = 1'b0;
      re_nxt       = 1'b0;
      reg_addr_nxt = reg_addr;
      wdata_nxt    = reg_wdata;

      if (msg_start) begin
         // also the abort path: any in-flight byte this cycle is dropped
         state_nxt   = CMD;
         tx_data_nxt = {msg_cnt, 3'b000, err_ovr};
         tx_load_nxt = 1'b1;
         cnt_nxt     = msg_cnt + 4'd1;
         err_nxt     = 1'b0;
         bytes_nxt   = '0;
         loaded_nxt  = 1'b0;
      end else if (msg_end && state != IDLE && state != DONE) begin
         state_nxt   = DONE;
         tx_data_nxt = '0;
      end else begin
         case (state)
            IDLE: ;
            CMD: begin
               if (rx_valid) begin
                  addr_nxt  = rx_data[ADDR_W-1:0];
                  bytes_nxt = '0;
                  state_nxt = rx_data[DATA_W-1] ? RD_REQ : WR;
               end
            end
            WR: begin
               if (rx_valid) begin
                  tx_load_nxt = 1'b1;
                  if (bytes == BMAX) begin
                     err_nxt     = 1'b1;
                     tx_data_nxt = '1;
                  end else begin
                     we_nxt       = 1'b1;
                     reg_addr_nxt = addr;
                     wdata_nxt    = rx_data;
                     tx_data_nxt  = '0;
                     bytes_nxt    = bytes_inc;
                     addr_nxt     = addr_adv;
                  end
               end
            end
            RD_REQ: begin
               re_nxt       = 1'b1;
               reg_addr_nxt = addr;
               loaded_nxt   = 1'b0;
               state_nxt    = RD_LD;
            end
            RD_LD: begin
               // reg_re is high during the first RD_LD cycle; capture at its end
               if (!loaded) begin
                  tx_data_nxt = reg_rdata;
                  tx_load_nxt = 1'b1;
                  loaded_nxt  = 1'b1;
               end else if (rx_valid) begin
                  if (bytes == BMAX) begin
                     err_nxt     = 1'b1;
                     tx_data_nxt = '1;
                     tx_load_nxt = 1'b1;
                  end else begin
                     bytes_nxt = bytes_inc;
                     addr_nxt  = addr_adv;
                     if (bytes_inc != BMAX)
                        state_nxt = RD_REQ;
                  end
               end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         bytes     <= '0;
         loaded    <= 1'b0;
         err_ovr   <= 1'b0;
         msg_cnt   <= '0;
         tx_data   <= '0;
         tx_load   <= 1'b0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
      end else begin
         state     <= state_nxt;
         addr      <= addr_nxt;
         bytes     <= bytes_nxt;
         loaded    <= loaded_nxt;
         err_ovr   <= err_nxt;
         msg_cnt   <= cnt_nxt;
         tx_data   <= tx_data_nxt;
         tx_load   <= tx_load_nxt;
         reg_we    <= we_nxt;
         reg_re    <= re_nxt;
         reg_addr  <= reg_addr_nxt;
         reg_wdata <= wdata_nxt;
      end
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: status byte, write/read bursts, overrun, abort and reset cases.
module tb_spi_reg_ctrl;

`ifdef SPI_REG_CTRL_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       msg_start = 1'b0;
   logic       msg_end = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = '0;
   logic [7:0] tx_data;
   logic       tx_load;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       busy;
   logic       err_ovr;

   int checks = 0;
   int failures = 0;
   int both_n = 0;
   logic [7:0] frames = '0;
   logic [7:0] mem [128];

   logic [6:0] we_a[$];
   logic [7:0] we_d[$];
   logic [6:0] re_a[$];
   logic [7:0] tx_q[$];

   spi_reg_ctrl dut (
      .clk(clk), .rst(rst), .msg_start(msg_start), .msg_end(msg_end),
      .rx_valid(rx_valid), .rx_data(rx_data), .tx_data(tx_data), .tx_load(tx_load),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
      .reg_rdata(reg_rdata), .busy(busy), .err_ovr(err_ovr)
   );

   always #5 clk = ~clk;

   assign reg_rdata = mem[reg_addr];

   always @(negedge clk) begin
      if (reg_we) begin
         we_a.push_back(reg_addr);
         we_d.push_back(reg_wdata);
      end
      if (reg_re) re_a.push_back(reg_addr);
      if (tx_load) tx_q.push_back(tx_data);
      if (reg_we && reg_re) both_n++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      we_a.delete(); we_d.delete(); re_a.delete(); tx_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      frames = '0;
      tick(1);
   endtask

   task automatic start_frame();
      msg_start = 1'b1;
      tick(1);
      msg_start = 1'b0;
      frames = frames + 8'd1;
      tick(2);
   endtask

   task automatic end_frame();
      msg_end = 1'b1;
      tick(1);
      msg_end = 1'b0;
      tick(3);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      tick(8);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      checks++;
      if ({tx_data, tx_load, reg_addr, reg_wdata} !== 24'h0) begin
         failures++; $display("FAIL reset_data got=%h exp=0", {tx_data, tx_load, reg_addr, reg_wdata});
      end
      checks++;
      if ({reg_we, reg_re, busy, err_ovr} !== 4'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=0000", {reg_we, reg_re, busy, err_ovr});
      end
      rst = 1'b0;
      frames = '0;
      tick(1);
   endtask

   task automatic test_status();
      logic [7:0] exp;
      do_reset();
      clear_logs();
      for (int i = 0; i < 3; i++) begin
         start_frame();
         checks++;
         if (busy !== 1'b1) begin
            failures++; $display("FAIL status_busy frame=%0d got=%b exp=1", i, busy);
         end
         end_frame();
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL status_idle got=%b exp=0", busy);
      end
      for (int i = 0; i < 3; i++) begin
         exp = 8'(i * 16);
         checks++;
         if (tx_q[i] !== exp) begin
            failures++; $display("FAIL status_byte frame=%0d got=%h exp=%h", i, tx_q[i], exp);
         end
      end
      checks++;
      if (we_a.size() + re_a.size() !== 0) begin
         failures++; $display("FAIL status_bus got=%0d exp=0", we_a.size() + re_a.size());
      end
   endtask

   task automatic test_write();
      logic [6:0] exp_a2;
      exp_a2 = AUTOINC ? 7'h06 : 7'h05;
      clear_logs();
      start_frame();
      send_byte(8'h05);
      send_byte(8'hAA);
      send_byte(8'h55);
      end_frame();
      checks++;
      if (we_a.size() !== 2) begin
         failures++; $display("FAIL write_count got=%0d exp=2", we_a.size());
      end
      checks++;
      if ({we_a[0], we_d[0]} !== {7'h05, 8'hAA}) begin
         failures++; $display("FAIL write_first got=%h/%h exp=05/aa", we_a[0], we_d[0]);
      end
      checks++;
      if ({we_a[1], we_d[1]} !== {exp_a2, 8'h55}) begin
         failures++; $display("FAIL write_second got=%h/%h exp=%h/55", we_a[1], we_d[1], exp_a2);
      end
      checks++;
      if (tx_q.size() !== 3 || tx_q[1] !== 8'h00 || tx_q[2] !== 8'h00) begin
         failures++; $display("FAIL write_tx got_n=%0d b1=%h b2=%h exp=3/00/00", tx_q.size(), tx_q[1], tx_q[2]);
      end
      checks++;
      if (re_a.size() !== 0) begin
         failures++; $display("FAIL write_no_read got=%0d exp=0", re_a.size());
      end
   endtask

   task automatic test_read();
      logic [7:0] exp_d2;
      logic [6:0] exp_a3;
      exp_d2 = AUTOINC ? 8'hC3 : 8'h3C;
      exp_a3 = AUTOINC ? 7'h07 : 7'h05;
      clear_logs();
      start_frame();
      send_byte(8'h85);
      send_byte(8'h00);
      send_byte(8'h00);
      end_frame();
      checks++;
      if (re_a.size() !== 3) begin
         failures++; $display("FAIL read_count got=%0d exp=3", re_a.size());
      end
      checks++;
      if (tx_q[1] !== 8'h3C) begin
         failures++; $display("FAIL read_byte1 got=%h exp=3c", tx_q[1]);
      end
      checks++;
      if (tx_q[2] !== exp_d2) begin
         failures++; $display("FAIL read_byte2 got=%h exp=%h", tx_q[2], exp_d2);
      end
      checks++;
      if (re_a[0] !== 7'h05 || re_a[2] !== exp_a3) begin
         failures++; $display("FAIL read_addr got=%h,%h exp=05,%h", re_a[0], re_a[2], exp_a3);
      end
      checks++;
      if (we_a.size() !== 0) begin
         failures++; $display("FAIL read_no_write got=%0d exp=0", we_a.size());
      end
   endtask

   task automatic test_addr_wrap();
      logic [6:0] exp_a2;
      exp_a2 = AUTOINC ? 7'h00 : 7'h7F;
      clear_logs();
      start_frame();
      send_byte(8'h7F);
      send_byte(8'h12);
      send_byte(8'h34);
      end_frame();
      checks++;
      if (we_a.size() !== 2 || we_a[0] !== 7'h7F || we_a[1] !== exp_a2) begin
         failures++; $display("FAIL addr_wrap got_n=%0d a0=%h a1=%h exp=2/7f/%h", we_a.size(), we_a[0], we_a[1], exp_a2);
      end
   endtask

   task automatic test_overrun();
      logic [6:0] exp_last;
      logic [7:0] f;
      logic [7:0] exp_st;
      exp_last = AUTOINC ? 7'h1F : 7'h10;
      clear_logs();
      start_frame();
      send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
      checks++;
      if (err_ovr !== 1'b0) begin
         failures++; $display("FAIL ovr_at_limit got=%b exp=0", err_ovr);
      end
      send_byte(8'hEE);
      checks++;
      if (err_ovr !== 1'b1) begin
         failures++; $display("FAIL ovr_flag got=%b exp=1", err_ovr);
      end
      end_frame();
      checks++;
      if (we_a.size() !== 16) begin
         failures++; $display("FAIL ovr_count got=%0d exp=16", we_a.size());
      end
      checks++;
      if ({we_a[15], we_d[15]} !== {exp_last, 8'hAF}) begin
         failures++; $display("FAIL ovr_last got=%h/%h exp=%h/af", we_a[15], we_d[15], exp_last);
      end
      checks++;
      if (tx_q.size() !== 18 || tx_q[16] !== 8'h00 || tx_q[17] !== 8'hFF) begin
         failures++; $display("FAIL ovr_tx got_n=%0d b16=%h b17=%h exp=18/00/ff", tx_q.size(), tx_q[16], tx_q[17]);
      end
      checks++;
      if (err_ovr !== 1'b1) begin
         failures++; $display("FAIL ovr_sticky got=%b exp=1", err_ovr);
      end
      f = frames;
      exp_st = {f[3:0], 4'b0001};
      clear_logs();
      start_frame();
      checks++;
      if (tx_q[0] !== exp_st) begin
         failures++; $display("FAIL ovr_status got=%h exp=%h", tx_q[0], exp_st);
      end
      checks++;
      if (err_ovr !== 1'b0) begin
         failures++; $display("FAIL ovr_clear got=%b exp=0", err_ovr);
      end
      end_frame();
   endtask

   task automatic test_end_collision();
      clear_logs();
      start_frame();
      send_byte(8'h30);
      msg_end = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'h99;
      tick(1);
      msg_end = 1'b0;
      rx_valid = 1'b0;
      checks++;
      if ({reg_we, tx_data, busy} !== {1'b0, 8'h00, 1'b1}) begin
         failures++; $display("FAIL end_coll_done we=%b tx=%h busy=%b exp=0/00/1", reg_we, tx_data, busy);
      end
      tick(1);
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL end_coll_idle got=%b exp=0", busy);
      end
      tick(3);
      checks++;
      if (we_a.size() !== 0) begin
         failures++; $display("FAIL end_coll_strobe got=%0d exp=0", we_a.size());
      end
   endtask

   task automatic test_restart();
      logic [7:0] f;
      logic [7:0] exp_st;
      clear_logs();
      start_frame();
      send_byte(8'h40);
      send_byte(8'h11);
      f = frames;
      exp_st = {f[3:0], 4'b0000};
      msg_start = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'h22;
      tick(1);
      msg_start = 1'b0;
      rx_valid = 1'b0;
      frames = frames + 8'd1;
      checks++;
      if ({tx_load, tx_data, reg_we} !== {1'b1, exp_st, 1'b0}) begin
         failures++; $display("FAIL restart_status load=%b tx=%h we=%b exp=1/%h/0", tx_load, tx_data, reg_we, exp_st);
      end
      tick(8);
      send_byte(8'h41);
      send_byte(8'h33);
      end_frame();
      checks++;
      if (we_a.size() !== 2) begin
         failures++; $display("FAIL restart_count got=%0d exp=2", we_a.size());
      end
      checks++;
      if ({we_a[0], we_d[0], we_a[1], we_d[1]} !== {7'h40, 8'h11, 7'h41, 8'h33}) begin
         failures++; $display("FAIL restart_writes got=%h/%h,%h/%h exp=40/11,41/33", we_a[0], we_d[0], we_a[1], we_d[1]);
      end
   endtask

   task automatic test_rst_mid();
      clear_logs();
      start_frame();
      rx_data = 8'h20;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      rst = 1'b1;
      tick(1);
      checks++;
      if ({tx_data, tx_load, reg_addr, reg_wdata, reg_we, reg_re, busy, err_ovr} !== 28'h0) begin
         failures++; $display("FAIL rst_mid_outputs got=%h exp=0",
            {tx_data, tx_load, reg_addr, reg_wdata, reg_we, reg_re, busy, err_ovr});
      end
      rst = 1'b0;
      frames = '0;
      send_byte(8'h77);
      end_frame();
      start_frame();
      rx_data = 8'h85;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      frames = '0;
      tick(6);
      checks++;
      if (we_a.size() + re_a.size() !== 0) begin
         failures++; $display("FAIL rst_mid_strobes we=%0d re=%0d exp=0/0", we_a.size(), re_a.size());
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_cnt_wrap();
      int bad;
      logic [7:0] iv;
      logic [7:0] exp;
      do_reset();
      bad = 0;
      for (int i = 0; i < 258; i++) begin
         clear_logs();
         msg_start = 1'b1;
         tick(1);
         msg_start = 1'b0;
         msg_end = 1'b1;
         tick(1);
         msg_end = 1'b0;
         tick(2);
         iv = 8'(i);
         exp = {iv[3:0], 4'b0000};
         if (tx_q.size() != 1 || tx_q[0] !== exp) bad++;
         if (i == 256) begin
            checks++;
            if (tx_q[0] !== 8'h00) begin
               failures++; $display("FAIL cnt_wrap_256 got=%h exp=00", tx_q[0]);
            end
         end
         if (i == 257) begin
            checks++;
            if (tx_q[0] !== 8'h10) begin
               failures++; $display("FAIL cnt_wrap_257 got=%h exp=10", tx_q[0]);
            end
         end
      end
      checks++;
      if (bad !== 0) begin
         failures++; $display("FAIL cnt_wrap_seq bad_frames=%0d exp=0", bad);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'(i ^ 8'h5A);
      mem[5] = 8'h3C;
      mem[6] = 8'hC3;
      test_reset();
      test_status();
      test_write();
      test_read();
      test_addr_wrap();
      test_overrun();
      test_end_collision();
      test_restart();
      test_rst_mid();
      test_cnt_wrap();
      checks++;
      if (both_n !== 0) begin
         failures++; $display("FAIL we_re_overlap got=%0d exp=0", both_n);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
